// File: rtl/ram_bank_pkg.sv
// Shared definitions for the 256-byte banked RAM read and write paths.
package ram_bank_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/bank_sel_decode.sv
// Bank select decode: 2-bit select to one-hot read enable, gated by en.
module bank_sel_decode
    import ram_bank_pkg::*;
(
    input  logic                  en,
    input  logic [BANK_SEL_W-1:0] sel,
    output logic [NUM_BANKS-1:0]  onehot
);

    // One comparator per bank; at most one can match, so the output is never multi-hot.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign onehot[g] = en && (sel == BANK_SEL_W'(g));
    end

endmodule

// File: rtl/ram_bank_reader.sv
// Read-side bank controller: accepts single/burst read requests, pulses one
// bank read enable per beat, waits the bank latency and returns each beat on
// a valid/ready response port. All outputs come straight from flops.
module ram_bank_reader
    import ram_bank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1    // legal range 1..4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [2:0]                    req_len,
    output logic [NUM_BANKS-1:0]          bank_rd_en,
    output logic [ADDR_W-3:0]             bank_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_last
);

    // Two bits cover lat_cnt values 0..3, i.e. RD_LAT 1..4.
    localparam int LAT_W = 2;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
    logic [2:0]              beats_left_q, beats_left_d;
    logic [BANK_SEL_W-1:0]   sel_q, sel_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;

    logic                    req_ready_d;
    logic [NUM_BANKS-1:0]    rd_en_d;
    logic [ADDR_W-3:0]       bank_addr_d;
    logic                    rsp_valid_d;
    logic [DATA_W-1:0]       rsp_data_d;
    logic                    rsp_last_d;
    logic                    issue_d;

    logic [DATA_W-1:0]       bank_word [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_unpack
        assign bank_word[g] = bank_rdata[g*DATA_W +: DATA_W];
    end

    // Enables are computed one cycle early (from the next-state address) so
    // that the registered pulse lands exactly in the ISSUE cycle.
    assign issue_d     = (state_d == ISSUE);
    assign req_ready_d = (state_d == IDLE);
    assign bank_addr_d = issue_d ? cur_addr_d[ADDR_W-3:0] : bank_addr;

    bank_sel_decode u_dec (
        .en     (issue_d),
        .sel    (cur_addr_d[ADDR_W-1 -: BANK_SEL_W]),
        .onehot (rd_en_d)
    );

    // Next-state and next-output logic; every target holds by default.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        sel_d        = sel_q;
        lat_cnt_d    = lat_cnt_q;
        rsp_valid_d  = rsp_valid;
        rsp_data_d   = rsp_data;
        rsp_last_d   = rsp_last;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cur_addr_d   = req_addr;
                    beats_left_d = req_len;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                sel_d     = cur_addr_q[ADDR_W-1 -: BANK_SEL_W];
                lat_cnt_d = LAT_W'(RD_LAT - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_data_d  = bank_word[sel_q];
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (beats_left_q == 3'd0);
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last) begin
                        state_d = IDLE;
                    end else begin
                        // Natural wrap: 0xFF + 1 continues at bank 0, address 0.
                        cur_addr_d   = cur_addr_q + 1'b1;
                        beats_left_d = beats_left_q - 3'd1;
                        state_d      = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            sel_q        <= '0;
            lat_cnt_q    <= '0;
            req_ready    <= 1'b0;
            bank_rd_en   <= '0;
            bank_addr    <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_last     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            sel_q        <= sel_d;
            lat_cnt_q    <= lat_cnt_d;
            req_ready    <= req_ready_d;
            bank_rd_en   <= rd_en_d;
            bank_addr    <= bank_addr_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            rsp_last     <= rsp_last_d;
        end
    end

endmodule
